hazard_stall_unit: RTL and testbench

- Producer-side stall/flush controller for the 5-stage pipeline; the counterpart to operand forwarding.
- Detects load-use hazards that forwarding cannot resolve and inserts one or more bubbles.
- Freezes the pipeline while the L1 data cache services a MEM-stage access, and gates the IF flush for taken branches.
- Sits beside the ID stage; drives write-enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_stall_unit_load_use_detect.sv | 15 +
 rtl/hazard_stall_unit.sv | 131 +++++++++++++
 tb/tb_hazard_stall_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller: FSM encoding and widths.
package hazard_pkg;
  localparam int REG_ADDR_W = 5;
  // Wide enough for LOAD_BUBBLES-1 with LOAD_BUBBLES up to 3
  localparam int BCNT_W     = 2;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    BUBBLE   = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_e;
endpackage

// File: rtl/hazard_stall_unit_load_use_detect.sv
// Load-use hazard compare: the EX-stage load writes a register that the ID-stage
// instruction reads. x0 never creates a hazard.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] IDRs1,
  input  logic [REG_ADDR_W-1:0] IDRs2,
  input  logic                  IDUseRs2,
  input  logic [REG_ADDR_W-1:0] EXRd,
  input  logic                  EXMemRead,
  output logic                  hz
);
  assign hz = EXMemRead & (EXRd != '0) &
              ((EXRd == IDRs1) | (IDUseRs2 & (EXRd == IDRs2)));
endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller beside the ID stage. Inserts load-use bubbles, freezes
// the pipe during dcache accesses and gates the taken-branch IF flush.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] IDRs1_i,
  input  logic [REG_ADDR_W-1:0] IDRs2_i,
  input  logic                  IDUseRs2_i,
  input  logic [REG_ADDR_W-1:0] EXRd_i,
  input  logic                  EXMemRead_i,
  input  logic                  MemReq_i,
  input  logic                  MemAck_i,
  input  logic                  IDBranch_i,
  output logic                  PCWrite_o,
  output logic                  IFIDWrite_o,
  output logic                  NoOp_o,
  output logic                  IFFlush_o,
  output logic                  PipeStall_o,
  output logic [1:0]            State_o,
  output logic [CNT_W-1:0]      LoadStallCnt_o,
  output logic [CNT_W-1:0]      MemStallCnt_o
);
  localparam logic [BCNT_W-1:0] BUB_RELOAD = BCNT_W'(LOAD_BUBBLES - 1);
  localparam bit                MULTI_BUB  = (LOAD_BUBBLES > 1);

  hz_state_e         state_q, state_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic              hz, memblk;
  logic              pc_we, ifid_we, noop, stall;

  load_use_detect u_lud (
    .IDRs1     (IDRs1_i),
    .IDRs2     (IDRs2_i),
    .IDUseRs2  (IDUseRs2_i),
    .EXRd      (EXRd_i),
    .EXMemRead (EXMemRead_i),
    .hz        (hz)
  );

  // An ack in the same cycle as the request means the access completes without stalling
  assign memblk = MemReq_i & ~MemAck_i;

  // State and bubble counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Mealy enables; the MEM_WAIT ack cycle behaves like RUN without memblk
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_we   = 1'b0;
    ifid_we = 1'b0;
    noop    = 1'b0;
    stall   = 1'b0;
    if (state_q == BUBBLE) begin
      noop = 1'b1;
      if (memblk) begin
        state_d = MEM_WAIT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - BCNT_W'(1);
        if (cnt_q == BCNT_W'(1)) state_d = RUN;
      end
    end else if (state_q == MEM_WAIT && !MemAck_i) begin
      stall = 1'b1;
    end else if (state_q == RUN && memblk) begin
      stall   = 1'b1;
      state_d = MEM_WAIT;
    end else if (state_q == RUN || state_q == MEM_WAIT) begin
      state_d = RUN;
      cnt_d   = '0;
      if (hz) begin
        noop = 1'b1;
        if (MULTI_BUB) begin
          state_d = BUBBLE;
          cnt_d   = BUB_RELOAD;
        end
      end else begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
      end
    end else begin
      // Unreachable encoding: recover to RUN holding the front end
      state_d = RUN;
      cnt_d   = '0;
      noop    = 1'b1;
    end
  end

  // Reset forces the documented safe values combinationally
  assign PCWrite_o   = ~rst_i & pc_we;
  assign IFIDWrite_o = ~rst_i & ifid_we;
  assign NoOp_o      = rst_i | noop;
  assign PipeStall_o = ~rst_i & stall;
  assign IFFlush_o   = IDBranch_i & PCWrite_o;
  assign State_o     = rst_i ? 2'b00 : state_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] ld_cnt_q, mem_cnt_q;

  // Saturating stall-cycle statistics
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ld_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      if (NoOp_o && !(&ld_cnt_q))       ld_cnt_q  <= ld_cnt_q + CNT_W'(1);
      if (PipeStall_o && !(&mem_cnt_q)) mem_cnt_q <= mem_cnt_q + CNT_W'(1);
    end
  end

  assign LoadStallCnt_o = ld_cnt_q;
  assign MemStallCnt_o  = mem_cnt_q;
`else
  assign LoadStallCnt_o = '0;
  assign MemStallCnt_o  = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: vector table, directed multi-cycle sequences and a
// randomized run against a behavioural model. Two instances: LOAD_BUBBLES=1 and 3.
module tb_hazard_stall_unit;
  localparam int CW1 = 32;
  localparam int CW3 = 4;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, exrd;
  logic use2, memrd, req, ack, br;

  logic pcw1, ifid1, noop1, fl1, st1;
  logic pcw3, ifid3, noop3, fl3, st3;
  logic [1:0] s1, s3;
  logic [CW1-1:0] lc1, mc1;
  logic [CW3-1:0] lc3, mc3;
  logic [6:0] o1, o3;

  assign o1 = {pcw1, ifid1, noop1, fl1, st1, s1};
  assign o3 = {pcw3, ifid3, noop3, fl3, st3, s3};

  always #5 clk = ~clk;

  hazard_stall_unit #(.LOAD_BUBBLES(1), .CNT_W(CW1)) u1 (
    .clk_i(clk), .rst_i(rst), .IDRs1_i(rs1), .IDRs2_i(rs2), .IDUseRs2_i(use2),
    .EXRd_i(exrd), .EXMemRead_i(memrd), .MemReq_i(req), .MemAck_i(ack),
    .IDBranch_i(br), .PCWrite_o(pcw1), .IFIDWrite_o(ifid1), .NoOp_o(noop1),
    .IFFlush_o(fl1), .PipeStall_o(st1), .State_o(s1),
    .LoadStallCnt_o(lc1), .MemStallCnt_o(mc1));

  hazard_stall_unit #(.LOAD_BUBBLES(3), .CNT_W(CW3)) u3 (
    .clk_i(clk), .rst_i(rst), .IDRs1_i(rs1), .IDRs2_i(rs2), .IDUseRs2_i(use2),
    .EXRd_i(exrd), .EXMemRead_i(memrd), .MemReq_i(req), .MemAck_i(ack),
    .IDBranch_i(br), .PCWrite_o(pcw3), .IFIDWrite_o(ifid3), .NoOp_o(noop3),
    .IFFlush_o(fl3), .PipeStall_o(st3), .State_o(s3),
    .LoadStallCnt_o(lc3), .MemStallCnt_o(mc3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; exrd = 0; use2 = 0; memrd = 0; req = 0; ack = 0; br = 0;
  endtask

  task automatic set_hz();
    memrd = 1; exrd = 5; rs1 = 5;
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1; #1; rst = 0;
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: is a dcache access outstanding, how many bubbles remain,
  // and the stall-cycle totals since reset.
  bit     m_wait[2];
  int     m_rem[2];
  longint m_ldc[2], m_mdc[2];
  bit     n_wait[2];
  int     n_rem[2];
  longint n_ldc[2], n_mdc[2];

  task automatic model(input int k, input int lb, input longint cmax,
                       output logic [6:0] eo, output longint elc, output longint emc);
    bit hz, blk, pcw, ifid, noop, stall, flush;
    logic [1:0] st;
    hz  = memrd && exrd != 0 && (exrd == rs1 || (use2 && exrd == rs2));
    blk = req && !ack;
    pcw = 0; ifid = 0; noop = 0; stall = 0;
    n_wait[k] = m_wait[k];
    n_rem[k]  = m_rem[k];
    st = m_wait[k] ? 2'd2 : (m_rem[k] > 0 ? 2'd1 : 2'd0);
    if (rst) begin
      noop = 1; st = 0; n_wait[k] = 0; n_rem[k] = 0;
    end else if (m_rem[k] > 0) begin
      noop = 1;
      if (blk) begin n_wait[k] = 1; n_rem[k] = 0; end
      else n_rem[k] = m_rem[k] - 1;
    end else if (m_wait[k] && !ack) begin
      stall = 1;
    end else if (!m_wait[k] && blk) begin
      stall = 1; n_wait[k] = 1;
    end else begin
      n_wait[k] = 0;
      if (hz) begin noop = 1; n_rem[k] = lb - 1; end
      else begin pcw = 1; ifid = 1; end
    end
    flush = br && pcw;
    eo  = {pcw, ifid, noop, flush, stall, st};
    elc = rst ? 0 : m_ldc[k];
    emc = rst ? 0 : m_mdc[k];
    if (!STATS) begin elc = 0; emc = 0; end
    n_ldc[k] = rst ? 0 : ((noop && m_ldc[k] < cmax) ? m_ldc[k] + 1 : m_ldc[k]);
    n_mdc[k] = rst ? 0 : ((stall && m_mdc[k] < cmax) ? m_mdc[k] + 1 : m_mdc[k]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] rs1, rs2, exrd;
    logic       use2, memrd, req, ack, br;
    logic [4:0] exp;  // {PCWrite, IFIDWrite, NoOp, IFFlush, PipeStall}
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [6:0] eo1, eo3;
    longint elc1, emc1, elc3, emc3;

    // rs1 rs2 exrd use2 memrd req ack br exp
    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5'b11000}; // idle
    vt[1]  = '{5, 0, 5, 0, 1, 0, 0, 0, 5'b00100}; // hz on rs1
    vt[2]  = '{1, 7, 7, 1, 1, 0, 0, 0, 5'b00100}; // hz on rs2
    vt[3]  = '{1, 7, 7, 0, 1, 0, 0, 0, 5'b11000}; // rs2 match, not read
    vt[4]  = '{0, 0, 0, 1, 1, 0, 0, 0, 5'b11000}; // x0 never hazards
    vt[5]  = '{5, 0, 5, 0, 0, 0, 0, 0, 5'b11000}; // EX not a load
    vt[6]  = '{0, 0, 0, 0, 0, 1, 0, 0, 5'b00001}; // dcache blocks
    vt[7]  = '{5, 0, 5, 0, 1, 1, 0, 0, 5'b00001}; // memblk beats hz
    vt[8]  = '{0, 0, 0, 0, 0, 1, 1, 0, 5'b11000}; // access done same cycle
    vt[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 5'b11000}; // stray ack
    vt[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 5'b11010}; // taken branch flushes
    vt[11] = '{5, 0, 5, 0, 1, 0, 0, 1, 5'b00100}; // flush held by bubble
    vt[12] = '{0, 0, 0, 0, 0, 1, 0, 1, 5'b00001}; // flush held by dcache

    // Reset values, regardless of inputs
    idle();
    rst = 1;
    set_hz(); req = 1; br = 1;
    #2;
    chk("reset_u1", 32'(o1), 32'(7'b0010000));
    chk("reset_u3", 32'(o3), 32'(7'b0010000));
    chk("reset_cnt", 32'(mc1 + lc1), 0);
    idle();
    step();
    rst = 0;

    // Table: each vector from RUN, checked before any clock edge
    for (int i = 0; i < 13; i++) begin
      step();
      rs1 = vt[i].rs1; rs2 = vt[i].rs2; exrd = vt[i].exrd; use2 = vt[i].use2;
      memrd = vt[i].memrd; req = vt[i].req; ack = vt[i].ack; br = vt[i].br;
      #1;
      chk($sformatf("vec%0d_u1", i), 32'(o1[6:2]), 32'(vt[i].exp));
      chk($sformatf("vec%0d_u3", i), 32'(o3[6:2]), 32'(vt[i].exp));
      chk($sformatf("vec%0d_state", i), 32'(s1), 0);
      idle();
      rst_pulse();
    end

    // Load-use with one bubble
    step(); rst_pulse();
    step(); set_hz(); #1;
    chk("lb1_bubble", 32'({noop1, pcw1}), 32'(2'b10));
    step(); idle(); #1;
    chk("lb1_resume", 32'({noop1, pcw1, ifid1}), 32'(3'b011));
    chk("lb1_ldcnt", 32'(lc1), STATS ? 1 : 0);

    // Load-use with three bubbles
    step(); rst_pulse();
    step(); set_hz(); #1;
    chk("lb3_c0", 32'({noop3, s3}), 32'(3'b100));
    step(); #1;
    chk("lb3_c1", 32'({noop3, s3}), 32'(3'b101));
    step(); #1;
    chk("lb3_c2", 32'({noop3, s3}), 32'(3'b101));
    step(); idle(); #1;
    chk("lb3_c3", 32'({noop3, pcw3, s3}), 32'(4'b0100));
    chk("lb3_ldcnt", 32'(lc3), STATS ? 3 : 0);

    // Dcache miss, ack four cycles after the request
    step(); rst_pulse();
    step();
    for (int i = 0; i < 4; i++) begin
      req = 1; ack = 0; #1;
      chk($sformatf("miss_stall%0d", i), 32'({st1, pcw1, ifid1, noop1}), 32'(4'b1000));
      step();
    end
    ack = 1; #1;
    chk("miss_ack", 32'({st1, pcw1, ifid1, s1}), 32'(5'b01110));
    step(); idle(); #1;
    chk("miss_cnt_u1", 32'(mc1), STATS ? 4 : 0);
    chk("miss_cnt_u3", 32'(mc3), STATS ? 4 : 0);

    // hz and memblk together
    step(); rst_pulse();
    step(); set_hz(); req = 1; #1;
    chk("sim_run", 32'({st1, noop1, st3, noop3}), 32'(4'b1010));
    step(); #1;
    chk("sim_wait", 32'({st1, s1}), 32'(3'b110));
    step(); ack = 1; #1;
    chk("sim_ack_u1", 32'({noop1, st1, pcw1}), 32'(3'b100));
    chk("sim_ack_u3", 32'({noop3, st3, pcw3}), 32'(3'b100));
    step(); idle(); #1;
    chk("sim_after_u1", 32'({noop1, pcw1, s1}), 32'(4'b0100));
    chk("sim_after_u3", 32'({noop3, s3}), 32'(3'b101));

    // Taken branch frozen behind a dcache stall
    step(); rst_pulse();
    step(); br = 1; req = 1; #1;
    chk("br_stall0", 32'(fl1), 0);
    step(); #1;
    chk("br_stall1", 32'(fl1), 0);
    step(); ack = 1; #1;
    chk("br_ack", 32'({fl1, fl3}), 32'(2'b11));
    step(); idle(); #1;
    chk("br_after", 32'({fl1, fl3}), 0);

    // Asynchronous reset in the middle of MEM_WAIT
    step(); rst_pulse();
    step(); req = 1; step(); #1;
    chk("ar_wait", 32'(s1), 2);
    rst = 1; #1;
    chk("ar_now", 32'(o1), 32'(7'b0010000));
    idle();
    step(); rst = 0; #1;
    chk("ar_release", 32'({s1, pcw1, s3, pcw3}), 32'(6'b001001));

    // Randomized run against the model
    step(); rst_pulse();
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 0; m_rem[k] = 0; m_ldc[k] = 0; m_mdc[k] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      step();
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      exrd  = 5'($urandom_range(0, 3));
      use2  = 1'($urandom_range(0, 1));
      memrd = 1'($urandom_range(0, 1));
      req   = ($urandom_range(0, 2) == 0);
      ack   = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      model(0, 1, 64'hFFFF_FFFF, eo1, elc1, emc1);
      model(1, 3, 64'd15, eo3, elc3, emc3);
      #1;
      chk("rand_u1", 32'(o1), 32'(eo1));
      chk("rand_u3", 32'(o3), 32'(eo3));
      chk("rand_cnt_u1", 32'(lc1) ^ {mc1[15:0], 16'h0}, 32'(elc1) ^ {16'(emc1), 16'h0});
      chk("rand_cnt_u3", 32'({lc3, mc3}), 32'({4'(elc3), 4'(emc3)}));
      for (int k = 0; k < 2; k++) begin
        m_wait[k] = n_wait[k]; m_rem[k] = n_rem[k];
        m_ldc[k] = n_ldc[k]; m_mdc[k] = n_mdc[k];
      end
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
